// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: start, LSB-first data, optional even parity, stop
module uart_tx_core #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int TW = $clog2(BIT_PERIOD);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = (timer_q == TW'(BIT_PERIOD - 1));

    always_comb begin
        state_d  = state_q;
        timer_d  = bit_end ? '0 : timer_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d  = '0;
                serial_d = 1'b1;
                if (tx_valid && ready_q) begin
                    // Start bit goes out on the accepting edge itself.
                    state_d  = START;
                    shift_d  = tx_data;
                    parity_d = ^tx_data;
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_d  = PARITY;
                            serial_d = parity_q;
                        end else begin
                            state_d  = STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    serial_d = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    serial_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready   = ready_q;
    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - bench for uart_tx_core with a frame-level line model
module tb_uart_tx_core;
    localparam int BP = 10;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [DB-1:0] data0 = '0, data1 = '0;
    logic          valid0 = 1'b0, valid1 = 1'b0;
    logic          ready0, ready1, so0, so1, busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    uart_tx_core #(.BIT_PERIOD(BP), .DATA_BITS(DB), .PARITY_EN(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .serial_out(so0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx_core #(.BIT_PERIOD(BP), .DATA_BITS(DB), .PARITY_EN(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .serial_out(so1), .tx_busy(busy1), .tx_done(done1)
    );

    int checks = 0;
    int errors = 0;

    // Model: a frame is a list of line levels; pos counts cycles since the accepting edge.
    int          pos [2];
    int          nbits [2];
    logic        exp_done [2];
    logic [10:0] bits [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_load(input int d, input logic [DB-1:0] b);
        bits[d] = '0;
        bits[d][0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[d][1+i] = b[i];
        if (d == 1) begin
            bits[d][DB+1] = ^b;
            bits[d][DB+2] = 1'b1;
            nbits[d] = DB + 3;
        end else begin
            bits[d][DB+1] = 1'b1;
            nbits[d] = DB + 2;
        end
    endfunction

    function automatic void model_edge();
        for (int d = 0; d < 2; d++) begin
            logic v;
            v = (d == 0) ? valid0 : valid1;
            exp_done[d] = 1'b0;
            if (!n_rst) begin
                pos[d] = -1;
            end else if (pos[d] < 0) begin
                if (v) begin
                    model_load(d, (d == 0) ? data0 : data1);
                    pos[d] = 0;
                end
            end else begin
                pos[d]++;
                if (pos[d] == nbits[d] * BP) begin
                    pos[d] = -1;
                    exp_done[d] = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic exp_line(input int d);
        return (pos[d] < 0) ? 1'b1 : bits[d][pos[d] / BP];
    endfunction

    task automatic check_all();
        chk("serial0", {31'b0, so0},    {31'b0, exp_line(0)});
        chk("ready0",  {31'b0, ready0}, {31'b0, pos[0] < 0});
        chk("busy0",   {31'b0, busy0},  {31'b0, pos[0] >= 0});
        chk("done0",   {31'b0, done0},  {31'b0, exp_done[0]});
        chk("serial1", {31'b0, so1},    {31'b0, exp_line(1)});
        chk("ready1",  {31'b0, ready1}, {31'b0, pos[1] < 0});
        chk("busy1",   {31'b0, busy1},  {31'b0, pos[1] >= 0});
        chk("done1",   {31'b0, done1},  {31'b0, exp_done[1]});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    // Sends one byte on an idle DUT; captures the mid-bit levels and edges until tx_done.
    task automatic run_frame(input int d, input logic [DB-1:0] b,
                             output logic [10:0] lv, output int len);
        int k;
        if (d == 0) begin data0 = b; valid0 = 1'b1; end
        else begin data1 = b; valid1 = 1'b1; end
        step(1);
        valid0 = 1'b0;
        valid1 = 1'b0;
        lv = '0;
        k = 0;
        while (k < 400) begin
            if ((k % BP) == BP / 2 && (k / BP) < 11) lv[k / BP] = (d == 0) ? so0 : so1;
            if (((d == 0) ? done0 : done1) === 1'b1) break;
            step(1);
            k++;
        end
        len = k;
    endtask

    task automatic wait_done0(input string tag);
        int k;
        k = 0;
        while (done0 !== 1'b1 && k < 400) begin
            step(1);
            k++;
        end
        chk(tag, {31'b0, done0}, 32'd1);
    endtask

    initial begin
        logic [10:0] lv;
        int          len;
        pos[0] = -1; pos[1] = -1;
        nbits[0] = DB + 2; nbits[1] = DB + 3;
        exp_done[0] = 1'b0; exp_done[1] = 1'b0;
        bits[0] = '0; bits[1] = '0;

        // Reset, then idle for 50 cycles.
        step(3);
        n_rst = 1'b1;
        step(50);

        // 0xA5 without parity: 10 bit levels, done 100 edges after accept.
        run_frame(0, 8'hA5, lv, len);
        chk("a5_levels", {22'b0, lv[9:0]}, 32'h34A);
        chk("a5_len", len, 32'd100);
        step(5);

        // Even parity frames.
        run_frame(1, 8'h07, lv, len);
        chk("p07_levels", {21'b0, lv}, 32'h60E);
        chk("p07_len", len, 32'd110);
        step(3);
        run_frame(1, 8'h03, lv, len);
        chk("p03_levels", {21'b0, lv}, 32'h406);
        chk("p03_len", len, 32'd110);
        step(3);

        // Back-to-back with tx_data changed mid-frame.
        data0 = 8'h00;
        valid0 = 1'b1;
        step(30);
        data0 = 8'hFF;
        wait_done0("b2b_done1");
        chk("b2b_gap_high", {31'b0, so0}, 32'd1);
        step(1);
        chk("b2b_restart", {31'b0, so0}, 32'd0);
        valid0 = 1'b0;
        step(1);
        wait_done0("b2b_done2");
        step(5);

        // Asynchronous reset during data bit 3.
        data0 = $urandom;
        valid0 = 1'b1;
        step(1);
        valid0 = 1'b0;
        step(BP * 4 + 3);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_serial", {31'b0, so0}, 32'd1);
        chk("rst_ready", {31'b0, ready0}, 32'd1);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_done", {31'b0, done0}, 32'd0);
        step(3);
        n_rst = 1'b1;
        step(2);
        run_frame(0, 8'h3C, lv, len);
        chk("3c_levels", {22'b0, lv[9:0]}, 32'h278);
        chk("3c_len", len, 32'd100);
        step(2);

        // A tx_valid pulse while busy is dropped.
        data0 = 8'h12;
        valid0 = 1'b1;
        step(1);
        valid0 = 1'b0;
        step(25);
        data0 = 8'h55;
        valid0 = 1'b1;
        step(1);
        valid0 = 1'b0;
        wait_done0("pulse_done");
        step(30);
        chk("pulse_idle", {31'b0, so0}, 32'd1);

        // Random traffic on both channels against the model.
        for (int i = 0; i < 1500; i++) begin
            data0  = $urandom;
            data1  = $urandom;
            valid0 = ($urandom_range(0, 3) == 0);
            valid1 = ($urandom_range(0, 3) == 0);
            step(1);
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        step(120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Serial UART transmitter. Pairs with the team's receiver path and reuses the same bit-timing scheme: a fixed number of clk cycles per bit, set by a parameter.
Accepts one parallel byte via a valid/ready handshake and shifts it out LSB-first. Frame format: one start bit, DATA_BITS data bits, an optional even-parity bit, one stop bit.
Sits between the host/transmit-FIFO logic and the serial pad.

Parameters:
BIT_PERIOD, 10, clk cycles per serial bit; legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous, active-low reset.
tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
tx_valid  input  1  host has a byte on tx_data.
tx_ready  output  1  block can accept a byte; high only in IDLE.
serial_out  output  1  UART line; idles high.
tx_busy  output  1  high while a frame is in progress (any state other than IDLE).
tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: async on n_rst low.
  - State = IDLE; serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Bit timer, bit index and shift register all cleared.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - serial_out=1.
  - Handshake = tx_valid & tx_ready at a rising edge.
  - On handshake: load tx_data into the shift register; compute parity = XOR of the data bits; clear the bit timer; go to START.
- START: serial_out=0 for exactly BIT_PERIOD cycles, then DATA.
- DATA:
  - serial_out = shift register bit 0; each level held BIT_PERIOD cycles.
  - Shift right after each bit.
  - After DATA_BITS bits, go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: serial_out = parity, held BIT_PERIOD cycles, then STOP.
- STOP:
  - serial_out=1 for BIT_PERIOD cycles, then IDLE.
  - tx_done=1 for exactly the first IDLE cycle after STOP.
- Bit timer:
  - Counts 0..BIT_PERIOD-1; width $clog2(BIT_PERIOD).
  - Reaching terminal count advances the bit and wraps the timer to 0 in the same edge.
  - The bit index counter is 0..DATA_BITS-1.
- Latency: serial_out falls on the same edge that accepts the handshake.
- Frame length: (2 + DATA_BITS + PARITY_EN) * BIT_PERIOD cycles, from the handshake edge to IDLE entry.
- Back-to-back: tx_ready rises in the first IDLE cycle. If tx_valid is already high, the next start bit begins at the following edge, giving exactly 1 idle-high cycle between frames.
- tx_data and tx_valid changes while busy are ignored. No byte is queued; a tx_valid pulse that ends before IDLE is lost.
- tx_done and a new handshake may occur in the same cycle.
- Reset mid-frame: the line returns high immediately, the frame is aborted, and no tx_done is generated.
- No glitches on serial_out: it is driven from a flop.

Test Plan:
1. Reset, then hold tx_valid=0 for 50 cycles -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
2. BIT_PERIOD=10, PARITY_EN=0: send 0xA5 -> serial_out levels 0,1,0,1,0,0,1,0,1,1, each held exactly 10 cycles; tx_done pulses 100 cycles after the handshake edge.
3. PARITY_EN=1: send 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop; frame is 110 cycles. Send 0x03 -> parity bit 0.
4. Hold tx_valid=1 with 0x00, then switch tx_data to 0xFF mid-frame -> first frame transmits all zeros; exactly 1 idle-high cycle; second frame transmits 0xFF; two tx_done pulses.
5. Assert n_rst low during data bit 3 -> serial_out=1 and tx_ready=1 asynchronously, no tx_done. After release, send 0x3C -> a complete, correct frame.
6. Pulse tx_valid for 1 cycle with 0x55 while busy -> ignored: no extra frame, and the line stays high after the current frame.
